// File: rtl/l1i_cache_assoc_if.sv
// Fetch, refill and result signals between the fetch front end and the
// set-associative L1 I-cache.
interface l1i_cache_assoc_if #(
  parameter int fetchingAddressWidth    = 64,
  parameter int cacheLineWith           = 512,
  parameter int instructionWidth        = 32,
  parameter int offsetWidth             = 6,
  parameter int indexWidth              = 6,
  parameter int fetchWidth              = 2,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int instructionCounterWidth = 64
);
  localparam int TAG_W = fetchingAddressWidth - indexWidth - offsetWidth;

  logic                                     fetch_en;
  logic                                     fetch_stall;
  logic [PidSize-1:0]                       pid;
  logic [TidSize-1:0]                       tid;
  logic [TAG_W-1:0]                         tag;
  logic [indexWidth-1:0]                    index;
  logic [offsetWidth-1:0]                   offset;

  logic                                     update;
  logic [fetchingAddressWidth-1:0]          update_addr;
  logic [cacheLineWith-1:0]                 update_line;
  logic [PidSize-1:0]                       update_pid;
  logic [TidSize-1:0]                       update_tid;

  logic [fetchWidth-1:0]                    fetched_valid;
  logic [fetchWidth*instructionWidth-1:0]   fetched_insts;
  logic [fetchingAddressWidth-1:0]          fetched_addr;
  logic [PidSize-1:0]                       fetched_pid;
  logic [TidSize-1:0]                       fetched_tid;
  logic [instructionCounterWidth-1:0]       fetched_id;

  logic                                     miss;
  logic [fetchingAddressWidth-1:0]          missed_addr;
  logic [instructionCounterWidth-1:0]       missed_id;
  logic [PidSize-1:0]                       missed_pid;
  logic [TidSize-1:0]                       missed_tid;
  logic                                     miss_pending;

  modport master (
    output fetch_en, fetch_stall, pid, tid, tag, index, offset,
           update, update_addr, update_line, update_pid, update_tid,
    input  fetched_valid, fetched_insts, fetched_addr, fetched_pid, fetched_tid,
           fetched_id, miss, missed_addr, missed_id, missed_pid, missed_tid,
           miss_pending
  );

  modport slave (
    input  fetch_en, fetch_stall, pid, tid, tag, index, offset,
           update, update_addr, update_line, update_pid, update_tid,
    output fetched_valid, fetched_insts, fetched_addr, fetched_pid, fetched_tid,
           fetched_id, miss, missed_addr, missed_id, missed_pid, missed_tid,
           miss_pending
  );
endinterface

// File: rtl/l1i_cache_assoc.sv
// Set-associative L1 I-cache: 2-cycle fetch pipeline, round-robin refill, miss FSM.
// Define L1I_PID_TAG_EN to store a PID per line and require it to match on hit.
//
// state     | meaning
// IDLE      | accepting fetches; refills act as prefetch fills
// MISS_WAIT | miss reported, fetches ignored until a refill arrives
module l1i_cache_assoc #(
  parameter int fetchingAddressWidth    = 64,
  parameter int cacheLineWith           = 512,
  parameter int instructionWidth        = 32,
  parameter int offsetWidth             = 6,
  parameter int indexWidth              = 6,
  parameter int numWays                 = 4,
  parameter int fetchWidth              = 2,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int instructionCounterWidth = 64
) (
  input logic               clk,
  input logic               rst,
  l1i_cache_assoc_if.slave  bus
);
  localparam int TAG_W      = fetchingAddressWidth - indexWidth - offsetWidth;
  localparam int SETS       = 1 << indexWidth;
  localparam int WORDS      = cacheLineWith / instructionWidth;
  localparam int WORD_IDX_W = offsetWidth - 2;
  localparam int WAY_W      = (numWays > 1) ? $clog2(numWays) : 1;
  localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(numWays - 1);
  localparam logic [instructionCounterWidth-1:0] ID_ONE = instructionCounterWidth'(1);

  typedef enum logic {IDLE, MISS_WAIT} state_t;
  state_t state, state_nxt;

  logic [cacheLineWith-1:0] data_mem  [numWays][SETS];
  logic [TAG_W-1:0]         tag_mem   [numWays][SETS];
  logic [SETS-1:0]          valid_mem [numWays];
  logic [WAY_W-1:0]         victim    [SETS];
`ifdef L1I_PID_TAG_EN
  logic [PidSize-1:0]       pid_mem   [numWays][SETS];
  logic [PidSize-1:0]       s2_way_pid [numWays];
`endif

  logic                     s2_pend;
  logic [TAG_W-1:0]         s2_tag;
  logic [indexWidth-1:0]    s2_index;
  logic [WORD_IDX_W-1:0]    s2_word;
  logic [PidSize-1:0]       s2_pid;
  logic [TidSize-1:0]       s2_tid;
  logic [cacheLineWith-1:0] s2_line      [numWays];
  logic [TAG_W-1:0]         s2_way_tag   [numWays];
  logic                     s2_way_valid [numWays];

  logic                     accept, miss_now, hit;
  logic [cacheLineWith-1:0] hit_line;
  logic [fetchWidth-1:0]    slot_valid;
  logic [fetchWidth*instructionWidth-1:0] slot_data;
  logic [instructionCounterWidth-1:0]     n_valid, id_cnt;

  logic [TAG_W-1:0]         upd_tag;
  logic [indexWidth-1:0]    upd_idx;
  logic [WAY_W-1:0]         fill_way, match_way, free_way;
  logic                     upd_match, upd_free, bump_victim;

  logic unused_bits;
`ifdef L1I_PID_TAG_EN
  assign unused_bits = ^{bus.update_tid, bus.update_addr[offsetWidth-1:0], bus.offset[1:0]};
`else
  assign unused_bits = ^{bus.update_tid, bus.update_pid, bus.update_addr[offsetWidth-1:0],
                         bus.offset[1:0]};
`endif

  assign upd_tag = bus.update_addr[fetchingAddressWidth-1 -: TAG_W];
  assign upd_idx = bus.update_addr[offsetWidth +: indexWidth];
  assign bus.miss_pending = (state == MISS_WAIT);

  // Refill way: existing copy of the line first, then lowest free way, then victim.
  always_comb begin
    upd_match = 1'b0;
    upd_free  = 1'b0;
    match_way = '0;
    free_way  = '0;
    for (int w = numWays - 1; w >= 0; w--) begin
`ifdef L1I_PID_TAG_EN
      if (valid_mem[w][upd_idx] && tag_mem[w][upd_idx] == upd_tag &&
          pid_mem[w][upd_idx] == bus.update_pid) begin
`else
      if (valid_mem[w][upd_idx] && tag_mem[w][upd_idx] == upd_tag) begin
`endif
        upd_match = 1'b1;
        match_way = WAY_W'(w);
      end
      if (!valid_mem[w][upd_idx]) begin
        upd_free = 1'b1;
        free_way = WAY_W'(w);
      end
    end
    fill_way    = upd_match ? match_way : (upd_free ? free_way : victim[upd_idx]);
    bump_victim = !upd_match && !upd_free;
  end

  always_ff @(posedge clk) begin
    if (bus.update) begin
      data_mem[fill_way][upd_idx] <= bus.update_line;
      tag_mem[fill_way][upd_idx]  <= upd_tag;
`ifdef L1I_PID_TAG_EN
      pid_mem[fill_way][upd_idx]  <= bus.update_pid;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < numWays; w++) valid_mem[w] <= '0;
      for (int s = 0; s < SETS; s++) victim[s] <= '0;
    end else if (bus.update) begin
      valid_mem[fill_way][upd_idx] <= 1'b1;
      if (bump_victim)
        victim[upd_idx] <= (victim[upd_idx] == LAST_WAY) ? '0 : victim[upd_idx] + 1'b1;
    end
  end

  // Stage 1: capture request and read every way of the set.
  always_ff @(posedge clk) begin
    if (accept) begin
      s2_tag   <= bus.tag;
      s2_index <= bus.index;
      s2_word  <= bus.offset[offsetWidth-1:2];
      s2_pid   <= bus.pid;
      s2_tid   <= bus.tid;
      for (int w = 0; w < numWays; w++) begin
        s2_line[w]      <= data_mem[w][bus.index];
        s2_way_tag[w]   <= tag_mem[w][bus.index];
        s2_way_valid[w] <= valid_mem[w][bus.index];
`ifdef L1I_PID_TAG_EN
        s2_way_pid[w]   <= pid_mem[w][bus.index];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      s2_pend <= 1'b0;
    else if (accept)
      s2_pend <= 1'b1;
    else if (!bus.fetch_stall)
      s2_pend <= 1'b0;
  end

  // Stage 2: tag compare and slot extraction; slots past the line end stay invalid.
  always_comb begin
    int wi;
    hit        = 1'b0;
    hit_line   = '0;
    slot_valid = '0;
    slot_data  = '0;
    n_valid    = '0;
    wi         = 0;
    for (int w = 0; w < numWays; w++) begin
`ifdef L1I_PID_TAG_EN
      if (s2_way_valid[w] && s2_way_tag[w] == s2_tag && s2_way_pid[w] == s2_pid) begin
`else
      if (s2_way_valid[w] && s2_way_tag[w] == s2_tag) begin
`endif
        hit      = 1'b1;
        hit_line = s2_line[w];
      end
    end
    for (int i = 0; i < fetchWidth; i++) begin
      wi = int'(s2_word) + i;
      if (wi < WORDS) begin
        slot_valid[fetchWidth-1-i] = 1'b1;
        slot_data[(fetchWidth-i)*instructionWidth-1 -: instructionWidth] =
          hit_line[cacheLineWith-1-wi*instructionWidth -: instructionWidth];
        n_valid = n_valid + ID_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    miss_now  = s2_pend && !hit && !bus.fetch_stall;
    case (state)
      IDLE: begin
        accept = bus.fetch_en && !bus.fetch_stall && !miss_now;
        if (miss_now) state_nxt = MISS_WAIT;
      end
      MISS_WAIT: begin
        if (bus.update) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs; a stall freezes everything except the miss pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.fetched_valid <= '0;
      bus.fetched_insts <= '0;
      bus.fetched_addr  <= '0;
      bus.fetched_pid   <= '0;
      bus.fetched_tid   <= '0;
      bus.fetched_id    <= '0;
      bus.miss          <= 1'b0;
      bus.missed_addr   <= '0;
      bus.missed_id     <= '0;
      bus.missed_pid    <= '0;
      bus.missed_tid    <= '0;
      id_cnt            <= '0;
    end else if (bus.fetch_stall) begin
      bus.miss <= 1'b0;
    end else begin
      bus.miss <= miss_now;
      if (s2_pend && hit) begin
        bus.fetched_valid <= slot_valid;
        bus.fetched_insts <= slot_data;
        bus.fetched_addr  <= {s2_tag, s2_index, s2_word, 2'b00};
        bus.fetched_pid   <= s2_pid;
        bus.fetched_tid   <= s2_tid;
        bus.fetched_id    <= id_cnt;
        id_cnt            <= id_cnt + n_valid;
      end else begin
        bus.fetched_valid <= '0;
      end
      if (miss_now) begin
        bus.missed_addr <= {s2_tag, s2_index, {offsetWidth{1'b0}}};
        bus.missed_id   <= id_cnt;
        bus.missed_pid  <= s2_pid;
        bus.missed_tid  <= s2_tid;
      end
    end
  end
endmodule

// File: tb/tb_l1i_cache_assoc.sv
// Directed bench for l1i_cache_assoc with default parameters (4-way, fetchWidth 2).
module tb_l1i_cache_assoc;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  l1i_cache_assoc_if bus ();
  l1i_cache_assoc dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] SA = 32'hAAAAAAAA;
  localparam logic [31:0] S6 = 32'h55555555;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] wv(input logic [31:0] seed, input int k);
    return seed + 32'(k) * 32'h11111111;
  endfunction

  function automatic logic [511:0] mk_line(input logic [31:0] seed);
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[511-32*k -: 32] = wv(seed, k);
    return l;
  endfunction

  function automatic logic [31:0] seed_of(input int k);
    return 32'h10000000 + 32'(k) * 32'h01000000;
  endfunction

  task automatic fetch(input logic [51:0] t, input logic [5:0] idx, input logic [5:0] off,
                       input logic [19:0] p);
    bus.fetch_en = 1'b1;
    bus.tag      = t;
    bus.index    = idx;
    bus.offset   = off;
    bus.pid      = p;
    bus.tid      = 16'h0042;
    tick();
    bus.fetch_en = 1'b0;
    tick();
  endtask

  task automatic fill(input logic [51:0] t, input logic [5:0] idx, input logic [31:0] seed,
                      input logic [19:0] p);
    bus.update      = 1'b1;
    bus.update_addr = {t, idx, 6'h0};
    bus.update_line = mk_line(seed);
    bus.update_pid  = p;
    bus.update_tid  = 16'h0007;
    tick();
    bus.update = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.fetch_en = 1'b0; bus.fetch_stall = 1'b0; bus.pid = '0; bus.tid = '0;
    bus.tag = '0; bus.index = '0; bus.offset = '0;
    bus.update = 1'b0; bus.update_addr = '0; bus.update_line = '0;
    bus.update_pid = '0; bus.update_tid = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", 64'(bus.fetched_valid), 64'h0);
    chk("rst_miss", 64'(bus.miss), 64'h0);
    chk("rst_pending", 64'(bus.miss_pending), 64'h0);
    chk("rst_id", bus.fetched_id, 64'h0);

    // cold miss
    fetch(52'h0, 6'd0, 6'd4, 20'd1);
    chk("t1_miss", 64'(bus.miss), 64'h1);
    chk("t1_missed_addr", bus.missed_addr, 64'h0);
    chk("t1_pending", 64'(bus.miss_pending), 64'h1);
    chk("t1_valid", 64'(bus.fetched_valid), 64'h0);
    chk("t1_missed_id", bus.missed_id, 64'h0);
    tick();
    chk("t1_pulse_end", 64'(bus.miss), 64'h0);
    chk("t1_still_pending", 64'(bus.miss_pending), 64'h1);
    fetch(52'h0, 6'd0, 6'd8, 20'd1);
    chk("t1_wait_ignores_fetch", 64'(bus.miss), 64'h0);
    chk("t1_wait_pending", 64'(bus.miss_pending), 64'h1);

    // refill then hit
    fill(52'h0, 6'd0, SA, 20'd1);
    chk("t2_pending_clr", 64'(bus.miss_pending), 64'h0);
    fetch(52'h0, 6'd0, 6'd4, 20'd1);
    chk("t2_valid", 64'(bus.fetched_valid), 64'h3);
    chk("t2_data", bus.fetched_insts, 64'hBBBBBBBB_CCCCCCCC);
    chk("t2_id", bus.fetched_id, 64'd0);
    chk("t2_addr", bus.fetched_addr, 64'd4);
    chk("t2_miss", 64'(bus.miss), 64'h0);

    // last word of the line
    fetch(52'h0, 6'd0, 6'd60, 20'd1);
    chk("t3_valid", 64'(bus.fetched_valid), 64'h2);
    chk("t3_data", bus.fetched_insts, {wv(SA, 15), 32'h0});
    chk("t3_id", bus.fetched_id, 64'd2);
    fetch(52'h0, 6'd0, 6'd0, 20'd1);
    chk("t3_next_id", bus.fetched_id, 64'd3);
    chk("t3_next_data", bus.fetched_insts, 64'hAAAAAAAA_BBBBBBBB);

    // five tags into one 4-way set: first one is evicted
    for (int k = 1; k <= 5; k++) fill(52'h100 + 52'(k), 6'd3, seed_of(k), 20'd1);
    fetch(52'h102, 6'd3, 6'd0, 20'd1);
    chk("t4_t2_valid", 64'(bus.fetched_valid), 64'h3);
    chk("t4_t2_data", bus.fetched_insts, {wv(seed_of(2), 0), wv(seed_of(2), 1)});
    chk("t4_t2_id", bus.fetched_id, 64'd5);
    fetch(52'h103, 6'd3, 6'd8, 20'd1);
    chk("t4_t3_data", bus.fetched_insts, {wv(seed_of(3), 2), wv(seed_of(3), 3)});
    chk("t4_t3_id", bus.fetched_id, 64'd7);
    fetch(52'h104, 6'd3, 6'd56, 20'd1);
    chk("t4_t4_valid", 64'(bus.fetched_valid), 64'h3);
    chk("t4_t4_data", bus.fetched_insts, {wv(seed_of(4), 14), wv(seed_of(4), 15)});
    fetch(52'h105, 6'd3, 6'd60, 20'd1);
    chk("t4_t5_valid", 64'(bus.fetched_valid), 64'h2);
    chk("t4_t5_data", bus.fetched_insts, {wv(seed_of(5), 15), 32'h0});
    chk("t4_t5_id", bus.fetched_id, 64'd11);
    fetch(52'h101, 6'd3, 6'd0, 20'd1);
    chk("t4_t1_miss", 64'(bus.miss), 64'h1);
    chk("t4_t1_missed_addr", bus.missed_addr, {52'h101, 6'd3, 6'd0});
    chk("t4_t1_missed_id", bus.missed_id, 64'd12);
    chk("t4_t1_missed_pid", 64'(bus.missed_pid), 64'd1);
    fill(52'h101, 6'd3, seed_of(1), 20'd1);
    fetch(52'h101, 6'd3, 6'd0, 20'd1);
    chk("t4_refill_hit", 64'(bus.fetched_valid), 64'h3);
    chk("t4_refill_data", bus.fetched_insts, {wv(seed_of(1), 0), wv(seed_of(1), 1)});
    chk("t4_refill_id", bus.fetched_id, 64'd12);

    // stall holds outputs and blocks acceptance
    fetch(52'h0, 6'd0, 6'd8, 20'd1);
    chk("t5_data", bus.fetched_insts, {wv(SA, 2), wv(SA, 3)});
    chk("t5_id", bus.fetched_id, 64'd14);
    bus.fetch_stall = 1'b1;
    bus.fetch_en = 1'b1;
    bus.offset = 6'd0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t5_hold_valid", 64'(bus.fetched_valid), 64'h3);
      chk("t5_hold_data", bus.fetched_insts, {wv(SA, 2), wv(SA, 3)});
      chk("t5_hold_id", bus.fetched_id, 64'd14);
    end
    bus.fetch_stall = 1'b0;
    bus.fetch_en = 1'b0;
    tick();
    chk("t5_no_accept", 64'(bus.fetched_valid), 64'h0);
    fetch(52'h0, 6'd0, 6'd0, 20'd1);
    chk("t5_after_id", bus.fetched_id, 64'd16);

    // PID-tagged match
    fill(52'h7, 6'd5, S6, 20'd1);
    fetch(52'h7, 6'd5, 6'd0, 20'd2);
`ifdef L1I_PID_TAG_EN
    chk("t6_pid_miss", 64'(bus.miss), 64'h1);
    chk("t6_pid_valid", 64'(bus.fetched_valid), 64'h0);
    chk("t6_missed_pid", 64'(bus.missed_pid), 64'd2);
    fill(52'h7, 6'd5, S6, 20'd2);
`else
    chk("t6_shared_miss", 64'(bus.miss), 64'h0);
    chk("t6_shared_valid", 64'(bus.fetched_valid), 64'h3);
    chk("t6_shared_data", bus.fetched_insts, {wv(S6, 0), wv(S6, 1)});
    chk("t6_shared_pid", 64'(bus.fetched_pid), 64'd2);
`endif

    // reset clears outputs and invalidates lines
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_id", bus.fetched_id, 64'h0);
    chk("rst2_data", bus.fetched_insts, 64'h0);
    chk("rst2_pending", 64'(bus.miss_pending), 64'h0);
    fetch(52'h0, 6'd0, 6'd4, 20'd1);
    chk("rst2_cold_miss", 64'(bus.miss), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
